board_control: RTL and testbench

- Sequencing FSM for the Othello board datapath.
- Turns level-held player keys into one-shot command pulses: move, erase old cell, draw cursor box, place disk, turn side.
- Scans a CELL x CELL pixel offset for each plot phase, and keeps a 64-bit occupancy map so a disk cannot be placed on a filled cell.
- Sits between the key/switch inputs, the board datapath (cursor position, plot base coordinates, colour select) and the VGA adapter write port.

---
 rtl/othello_pkg.sv | 28 ++
 rtl/board_control_if.sv | 39 +++
 rtl/cell_scanner.sv | 49 ++++
 rtl/board_control.sv | 169 ++++++++++++++++
 tb/tb_board_control.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/othello_pkg.sv
// Shared definitions for the Othello board controller slice.
// Holds the controller state encoding, direction codes, the default cell
// size and the board dimension.
package othello_pkg;

    localparam int unsigned CELL_DEFAULT = 12;
    localparam int unsigned BOARD_DIM    = 8;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        MOVE       = 4'd1,
        SETTLE     = 4'd2,
        ERASE      = 4'd3,
        BOX        = 4'd4,
        PLACE_CHK  = 4'd5,
        PLACE_DRAW = 4'd6,
        TURN       = 4'd7,
        RELEASE    = 4'd8
    } state_t;

endpackage

// File: rtl/board_control_if.sv
// Controller <-> board datapath / VGA write port bundle.
//   x, y          : current cursor cell from the datapath
//   move_*        : one-shot move commands to the datapath
//   plot_empty    : erase the old cell (background colour)
//   plot_box      : draw the cursor box
//   place_disk    : draw the player's disk
//   turn_side     : swap the active player
//   plot          : VGA write enable
//   off_x, off_y  : pixel offset inside the cell being drawn
// master = controller side, slave = datapath side.
interface board_control_if;
    logic [2:0] x;
    logic [2:0] y;
    logic       move_up;
    logic       move_down;
    logic       move_left;
    logic       move_right;
    logic       plot_empty;
    logic       plot_box;
    logic       place_disk;
    logic       turn_side;
    logic       plot;
    logic [3:0] off_x;
    logic [3:0] off_y;

    modport master (
        input  x, y,
        output move_up, move_down, move_left, move_right,
        output plot_empty, plot_box, place_disk, turn_side,
        output plot, off_x, off_y
    );

    modport slave (
        output x, y,
        input  move_up, move_down, move_left, move_right,
        input  plot_empty, plot_box, place_disk, turn_side,
        input  plot, off_x, off_y
    );
endinterface

// File: rtl/cell_scanner.sv
// Row-major pixel scan over a CELL x CELL square, x fastest.
//   clock, resetn : clock and asynchronous active-high reset
//   start         : (re)start the scan at (0,0) on the next edge
//   plot          : high while a pixel offset is being presented
//   off_x, off_y  : current pixel offset
//   done          : high during the last pixel (CELL-1, CELL-1)
// A start during the last pixel restarts seamlessly, so two phases can
// be drawn back to back without a gap.
module cell_scanner
    import othello_pkg::*;
#(
    parameter int unsigned CELL = CELL_DEFAULT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    output logic       plot,
    output logic [3:0] off_x,
    output logic [3:0] off_y,
    output logic       done
);
    localparam logic [3:0] LAST = 4'(CELL - 1);

    assign done = plot && (off_x == LAST) && (off_y == LAST);

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            plot  <= 1'b0;
            off_x <= '0;
            off_y <= '0;
        end else if (start) begin
            plot  <= 1'b1;
            off_x <= '0;
            off_y <= '0;
        end else if (plot) begin
            if (off_x == LAST) begin
                off_x <= '0;
                if (off_y == LAST) begin
                    off_y <= '0;
                    plot  <= 1'b0;
                end else begin
                    off_y <= off_y + 4'd1;
                end
            end else begin
                off_x <= off_x + 4'd1;
            end
        end
    end
endmodule

// File: rtl/board_control.sv
// Sequencing FSM for the Othello board datapath.
//   clock, resetn         : clock and asynchronous active-high reset
//   key_up/down/left/right: level-held direction keys
//   key_place             : level-held place key
//   dp (master)           : cursor in, move/draw commands and VGA port out
//   reject                : one-cycle pulse when placing on a filled cell
//   busy                  : high whenever the FSM is not idle
// Each held key yields exactly one operation; RELEASE waits for all keys
// to be released before accepting another.
module board_control
    import othello_pkg::*;
#(
    parameter int unsigned CELL      = CELL_DEFAULT,
    parameter int unsigned MOVE_HOLD = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             key_up,
    input  logic             key_down,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_place,
    board_control_if.master  dp,
    output logic             reject,
    output logic             busy
);
    localparam int unsigned    HW        = (MOVE_HOLD > 1) ? $clog2(MOVE_HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MOVE_HOLD - 1);

    state_t                         state;
    dir_t                           dir;
    dir_t                           next_dir;
    logic [HW-1:0]                  hold_cnt;
    logic                           move_on;
    logic                           plot_empty_r;
    logic                           plot_box_r;
    logic                           place_disk_r;
    logic                           turn_side_r;
    logic [BOARD_DIM*BOARD_DIM-1:0] occ;
    logic [5:0]                     cell_idx;
    logic                           cell_full;
    logic                           any_dir;
    logic                           any_key;
    logic                           scan_start;
    logic                           scan_plot;
    logic                           scan_done;
    logic [3:0]                     scan_x;
    logic [3:0]                     scan_y;

    assign cell_idx  = {dp.y, dp.x};
    assign cell_full = occ[cell_idx];
    assign any_dir   = key_up | key_down | key_left | key_right;
    assign any_key   = any_dir | key_place;

    always_comb begin
        next_dir = RIGHT;
        if (key_up)        next_dir = UP;
        else if (key_down) next_dir = DOWN;
        else if (key_left) next_dir = LEFT;
    end

    // The scanner is kicked one cycle ahead of each draw phase so its
    // first pixel lines up with the registered phase flag.
    assign scan_start = (state == SETTLE)
                      || ((state == ERASE) && scan_done)
                      || ((state == PLACE_CHK) && !cell_full);

    cell_scanner #(.CELL(CELL)) u_scan (
        .clock  (clock),
        .resetn (resetn),
        .start  (scan_start),
        .plot   (scan_plot),
        .off_x  (scan_x),
        .off_y  (scan_y),
        .done   (scan_done)
    );

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state        <= IDLE;
            dir          <= UP;
            hold_cnt     <= '0;
            move_on      <= 1'b0;
            plot_empty_r <= 1'b0;
            plot_box_r   <= 1'b0;
            place_disk_r <= 1'b0;
            turn_side_r  <= 1'b0;
            reject       <= 1'b0;
            occ          <= '0;
        end else begin
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_place) begin
                        state <= PLACE_CHK;
                    end else if (any_dir) begin
                        state    <= MOVE;
                        dir      <= next_dir;
                        hold_cnt <= '0;
                        move_on  <= 1'b1;
                    end
                end
                MOVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        move_on <= 1'b0;
                        state   <= SETTLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                SETTLE: begin
                    plot_empty_r <= 1'b1;
                    state        <= ERASE;
                end
                ERASE: begin
                    if (scan_done) begin
                        plot_empty_r <= 1'b0;
                        plot_box_r   <= 1'b1;
                        state        <= BOX;
                    end
                end
                BOX: begin
                    if (scan_done) begin
                        plot_box_r <= 1'b0;
                        state      <= RELEASE;
                    end
                end
                PLACE_CHK: begin
                    if (cell_full) begin
                        reject <= 1'b1;
                        state  <= RELEASE;
                    end else begin
                        occ[cell_idx] <= 1'b1;
                        place_disk_r  <= 1'b1;
                        state         <= PLACE_DRAW;
                    end
                end
                PLACE_DRAW: begin
                    if (scan_done) begin
                        place_disk_r <= 1'b0;
                        turn_side_r  <= 1'b1;
                        state        <= TURN;
                    end
                end
                TURN: begin
                    turn_side_r <= 1'b0;
                    state       <= RELEASE;
                end
                RELEASE: begin
                    if (!any_key) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign dp.move_up    = move_on && (dir == UP);
    assign dp.move_down  = move_on && (dir == DOWN);
    assign dp.move_left  = move_on && (dir == LEFT);
    assign dp.move_right = move_on && (dir == RIGHT);
    assign dp.plot_empty = plot_empty_r;
    assign dp.plot_box   = plot_box_r;
    assign dp.place_disk = place_disk_r;
    assign dp.turn_side  = turn_side_r;
    assign dp.plot       = scan_plot;
    assign dp.off_x      = scan_x;
    assign dp.off_y      = scan_y;
endmodule

// File: tb/tb_board_control.sv
// Scoreboard bench for board_control. The stimulus side predicts every
// non-idle output cycle (with its absolute cycle number) from the
// operation rules and queues it; the monitor compares each cycle.
module tb_board_control;
    import othello_pkg::*;

    localparam int unsigned CELL = 12;
    localparam int unsigned HOLD = 2;
    localparam int unsigned NPIX = CELL * CELL;

    typedef struct {
        int unsigned cyc;
        logic [17:0] outs;
    } exp_t;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_place = 1'b0;
    logic reject, busy;

    board_control_if bus();

    board_control #(.CELL(CELL), .MOVE_HOLD(HOLD)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_place (key_place),
        .dp        (bus.master),
        .reject    (reject),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    exp_t q[$];
    bit   occ [64];
    int unsigned errors = 0;
    int unsigned checks = 0;

    // {move_up,down,left,right, plot_empty, plot_box, place_disk, turn_side, plot, reject, off_x, off_y}
    function automatic logic [17:0] pack(input logic [3:0] mv, input logic pe, input logic pb,
                                         input logic pd, input logic ts, input logic pl,
                                         input logic rj, input logic [3:0] ox, input logic [3:0] oy);
        return {mv, pe, pb, pd, ts, pl, rj, ox, oy};
    endfunction

    function automatic logic [17:0] observed();
        return pack({bus.move_up, bus.move_down, bus.move_left, bus.move_right},
                    bus.plot_empty, bus.plot_box, bus.place_disk, bus.turn_side,
                    bus.plot, reject, bus.off_x, bus.off_y);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic push(input int unsigned c, input logic [17:0] o);
        exp_t e;
        e.cyc  = c;
        e.outs = o;
        q.push_back(e);
    endtask

    // Reference model: k = {place, up, down, left, right}, n = edge that samples the keys.
    // Returns the first cycle the controller sits in RELEASE.
    task automatic push_op(input logic [4:0] k, input int unsigned n, input int unsigned x,
                           input int unsigned y, output int unsigned rel);
        int unsigned d;
        if (k[4]) begin
            if (occ[y*8 + x]) begin
                push(n + 1, pack(4'b0, 0, 0, 0, 0, 0, 1, 4'd0, 4'd0));
                rel = n + 1;
            end else begin
                occ[y*8 + x] = 1'b1;
                for (int unsigned i = 0; i < NPIX; i++)
                    push(n + 1 + i, pack(4'b0, 0, 0, 1, 0, 1, 0, 4'(i % CELL), 4'(i / CELL)));
                push(n + 1 + NPIX, pack(4'b0, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0));
                rel = n + 2 + NPIX;
            end
        end else begin
            d = k[3] ? 0 : k[2] ? 1 : k[1] ? 2 : 3;
            for (int unsigned h = 0; h < HOLD; h++)
                push(n + h, pack(4'b1000 >> d, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0));
            for (int unsigned i = 0; i < NPIX; i++) begin
                push(n + HOLD + 1 + i, pack(4'b0, 1, 0, 0, 0, 1, 0, 4'(i % CELL), 4'(i / CELL)));
            end
            for (int unsigned i = 0; i < NPIX; i++) begin
                push(n + HOLD + 1 + NPIX + i, pack(4'b0, 0, 1, 0, 0, 1, 0, 4'(i % CELL), 4'(i / CELL)));
            end
            rel = n + HOLD + 1 + 2*NPIX;
        end
    endtask

    task automatic set_keys(input logic [4:0] k);
        {key_place, key_up, key_down, key_left, key_right} = k;
    endtask

    task automatic run_op(input logic [4:0] k, input int unsigned x, input int unsigned y,
                          input int unsigned extra, input bit churn, input bit rel_reset);
        int unsigned n, rel;
        @(negedge clock);
        set_keys(k);
        bus.x = 3'(x);
        bus.y = 3'(y);
        if (rel_reset) resetn = 1'b0;
        n = cyc + 1;
        push_op(k, n, x, y, rel);
        while (cyc < rel + extra) begin
            @(negedge clock);
            if (churn && cyc >= n) set_keys(5'($urandom_range(1, 31)));
            if (churn && cyc >= n + 1) begin
                bus.x = 3'($urandom_range(0, 7));
                bus.y = 3'($urandom_range(0, 7));
            end
        end
        chk("busy_held", 32'(busy), 32'd1);
        set_keys(5'b0);
        @(negedge clock);
        chk("busy_fall", 32'(busy), 32'd0);
    endtask

    // Monitor: every expected entry is compared at its exact cycle; any
    // other non-idle output cycle is unexpected.
    initial begin
        exp_t e;
        logic [17:0] obs;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                obs = observed();
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    checks++;
                    if (obs !== e.outs) begin
                        errors++;
                        $display("FAIL output_event cyc=%0d got=%05h required=%05h", cyc, obs, e.outs);
                    end
                end else if (obs != '0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d got=%05h required=00000", cyc, obs);
                end
            end
        end
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, rel, target;
        foreach (occ[i]) occ[i] = 1'b0;
        bus.x = 3'd0;
        bus.y = 3'd0;

        // Reset with key_right already held.
        set_keys(5'b00001);
        repeat (3) begin
            @(negedge clock);
            chk("reset_outputs", 32'(observed()), 32'd0);
            chk("reset_busy", 32'(busy), 32'd0);
        end
        run_op(5'b00001, 2, 5, 3, 1'b0, 1'b1);

        // key_down held for 1000 cycles.
        run_op(5'b00100, 0, 0, 1000 - (HOLD + 1 + 2*NPIX), 1'b0, 1'b0);

        // Place at (3,4), then again on the same cell.
        run_op(5'b10000, 3, 4, 2, 1'b0, 1'b0);
        run_op(5'b10000, 3, 4, 1, 1'b0, 1'b0);

        // Place and left together: placement wins.
        run_op(5'b10010, 6, 1, 0, 1'b0, 1'b0);

        // Random operations with key churn while busy.
        for (int unsigned r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run_op(5'($urandom_range(1, 31)), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 4), 1'b1, 1'b0);
        end

        // Reset in the middle of ERASE at offset (5,2).
        @(negedge clock);
        set_keys(5'b01000);
        n = cyc + 1;
        push_op(5'b01000, n, 0, 0, rel);
        target = n + HOLD + 1 + 2*CELL + 5;
        while (cyc < target) @(negedge clock);
        #1;
        resetn = 1'b1;
        set_keys(5'b0);
        #1;
        chk("abort_outputs", 32'(observed()), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        q.delete();
        foreach (occ[i]) occ[i] = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b0;

        // Previously filled cell is accepted after reset.
        run_op(5'b10000, 3, 4, 1, 1'b0, 1'b0);

        repeat (5) @(negedge clock);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
